// File: rtl/cache_meta_array.sv
`default_nettype none
// =============================================================================
// cache_meta_array : set-associative tag/valid/dirty/LRU store with hit and
//                    victim selection for the I/D cache controllers.
// Rev 1.0
// =============================================================================

module cache_meta_array #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 6,
  parameter int IDX_W = $clog2(SETS),
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [IDX_W-1:0] i_req_idx,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic             i_req_dirty,
  output logic             o_resp_valid,
  output logic             o_resp_hit,
  output logic [WAYS-1:0]  o_resp_way,
  output logic [WAYS-1:0]  o_resp_victim_way,
  output logic             o_resp_victim_valid,
  output logic             o_resp_victim_dirty,
  output logic [TAG_W-1:0] o_resp_victim_tag,
  output logic             o_busy
);

  localparam logic [1:0]       c_OP_LOOKUP = 2'b00;
  localparam logic [1:0]       c_OP_FILL   = 2'b01;
  localparam logic [1:0]       c_OP_INVAL  = 2'b10;
  localparam logic [1:0]       c_OP_FLUSH  = 2'b11;
  localparam logic [0:0]       c_ST_IDLE   = 1'b0;
  localparam logic [0:0]       c_ST_FLUSH  = 1'b1;
  localparam logic [WAYS-1:0]  c_WAY_ONE   = {{(WAYS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] c_LAST_SET  = IDX_W'(SETS - 1);
  localparam logic [AGE_W-1:0] c_AGE_OLD   = AGE_W'(WAYS - 1);

  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [AGE_W-1:0] r_age   [SETS][WAYS];

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_fcnt;

  logic             r_resp_valid;
  logic             r_resp_hit;
  logic [WAYS-1:0]  r_resp_way;
  logic [WAYS-1:0]  r_resp_victim_way;
  logic             r_resp_victim_valid;
  logic             r_resp_victim_dirty;
  logic [TAG_W-1:0] r_resp_victim_tag;

  logic             w_accept;
  logic [WAYS-1:0]  w_set_valid;
  logic [WAYS-1:0]  w_set_dirty;
  logic             w_hit;
  logic [AGE_W-1:0] w_hit_idx;
  logic             w_inv_any;
  logic [AGE_W-1:0] w_inv_idx;
  logic [AGE_W-1:0] w_lru_idx;
  logic [AGE_W-1:0] w_vic_idx;
  logic [AGE_W-1:0] w_touch_idx;
  logic [AGE_W-1:0] w_touch_age;
  logic [AGE_W-1:0] w_new_age [WAYS];
  logic             w_do_touch;
  logic [WAYS-1:0]  w_hit_oh;
  logic [WAYS-1:0]  w_vic_oh;

  logic [WAYS-1:0]  w_nxt_way;
  logic [WAYS-1:0]  w_nxt_vway;
  logic             w_nxt_vvalid;
  logic             w_nxt_vdirty;
  logic [TAG_W-1:0] w_nxt_vtag;

  assign o_req_ready = (r_state == c_ST_IDLE);
  assign o_busy      = (r_state == c_ST_FLUSH);
  assign w_accept    = i_req_valid & o_req_ready;

  assign w_set_valid = r_valid[i_req_idx];
  assign w_set_dirty = r_dirty[i_req_idx];

  // Descending scan so the lowest matching / invalid way is the one kept.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_inv_any = 1'b0;
    w_inv_idx = '0;
    w_lru_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_set_valid[w] && (r_tag[i_req_idx][w] == i_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = AGE_W'(w);
      end
      if (!w_set_valid[w]) begin
        w_inv_any = 1'b1;
        w_inv_idx = AGE_W'(w);
      end
      if (r_age[i_req_idx][w] == c_AGE_OLD) begin
        w_lru_idx = AGE_W'(w);
      end
    end
  end

  assign w_vic_idx   = w_inv_any ? w_inv_idx : w_lru_idx;
  assign w_hit_oh    = c_WAY_ONE << w_hit_idx;
  assign w_vic_oh    = c_WAY_ONE << w_vic_idx;
  assign w_touch_idx = w_hit ? w_hit_idx : w_vic_idx;
  assign w_touch_age = r_age[i_req_idx][w_touch_idx];
  assign w_do_touch  = ((i_req_op == c_OP_LOOKUP) && w_hit) || (i_req_op == c_OP_FILL);

  // Move-to-front: everything younger than the touched way ages by one.
  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_age
      assign w_new_age[g] = (AGE_W'(g) == w_touch_idx) ? '0 :
                            (r_age[i_req_idx][g] < w_touch_age) ? r_age[i_req_idx][g] + AGE_W'(1) :
                            r_age[i_req_idx][g];
    end
  endgenerate

  always_comb begin
    w_nxt_way    = w_hit ? w_hit_oh : ((i_req_op == c_OP_FILL) ? w_vic_oh : '0);
    w_nxt_vway   = w_vic_oh;
    w_nxt_vvalid = w_set_valid[w_vic_idx];
    w_nxt_vdirty = w_set_dirty[w_vic_idx];
    w_nxt_vtag   = r_tag[i_req_idx][w_vic_idx];
    // An invalidate reports the line being dropped so it can be written back.
    if ((i_req_op == c_OP_INVAL) && w_hit) begin
      w_nxt_vway   = w_hit_oh;
      w_nxt_vvalid = 1'b1;
      w_nxt_vdirty = w_set_dirty[w_hit_idx];
      w_nxt_vtag   = r_tag[i_req_idx][w_hit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w] <= '0;
          r_age[s][w] <= AGE_W'(w);
        end
      end
    end else if (r_state == c_ST_FLUSH) begin
      r_valid[r_fcnt] <= '0;
      r_dirty[r_fcnt] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_age[r_fcnt][w] <= AGE_W'(w);
      end
    end else if (w_accept) begin
      if (w_do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[i_req_idx][w] <= w_new_age[w];
        end
      end
      case (i_req_op)
        c_OP_LOOKUP, c_OP_FILL: begin
          if (w_hit) begin
            if (i_req_dirty) begin
              r_dirty[i_req_idx][w_hit_idx] <= 1'b1;
            end
          end else if (i_req_op == c_OP_FILL) begin
            r_tag[i_req_idx][w_vic_idx]   <= i_req_tag;
            r_valid[i_req_idx][w_vic_idx] <= 1'b1;
            r_dirty[i_req_idx][w_vic_idx] <= i_req_dirty;
          end
        end
        c_OP_INVAL: begin
          if (w_hit) begin
            r_valid[i_req_idx][w_hit_idx] <= 1'b0;
            r_dirty[i_req_idx][w_hit_idx] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= c_ST_IDLE;
      r_fcnt              <= '0;
      r_resp_valid        <= 1'b0;
      r_resp_hit          <= 1'b0;
      r_resp_way          <= '0;
      r_resp_victim_way   <= '0;
      r_resp_victim_valid <= 1'b0;
      r_resp_victim_dirty <= 1'b0;
      r_resp_victim_tag   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            if (i_req_op == c_OP_FLUSH) begin
              r_state <= c_ST_FLUSH;
              r_fcnt  <= '0;
            end else begin
              r_resp_valid        <= 1'b1;
              r_resp_hit          <= w_hit;
              r_resp_way          <= w_nxt_way;
              r_resp_victim_way   <= w_nxt_vway;
              r_resp_victim_valid <= w_nxt_vvalid;
              r_resp_victim_dirty <= w_nxt_vdirty;
              r_resp_victim_tag   <= w_nxt_vtag;
            end
          end
        end
        c_ST_FLUSH: begin
          if (r_fcnt == c_LAST_SET) begin
            r_state             <= c_ST_IDLE;
            r_fcnt              <= '0;
            r_resp_valid        <= 1'b1;
            r_resp_hit          <= 1'b0;
            r_resp_way          <= '0;
            r_resp_victim_way   <= '0;
            r_resp_victim_valid <= 1'b0;
            r_resp_victim_dirty <= 1'b0;
            r_resp_victim_tag   <= '0;
          end else begin
            r_fcnt <= r_fcnt + IDX_W'(1);
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign o_resp_valid        = r_resp_valid;
  assign o_resp_hit          = r_resp_hit;
  assign o_resp_way          = r_resp_way;
  assign o_resp_victim_way   = r_resp_victim_way;
  assign o_resp_victim_valid = r_resp_victim_valid;
  assign o_resp_victim_dirty = r_resp_victim_dirty;
  assign o_resp_victim_tag   = r_resp_victim_tag;

endmodule

`default_nettype wire

// File: tb/tb_cache_meta_array.sv
`default_nettype none
// =============================================================================
// tb_cache_meta_array : scoreboard bench for a 2-way/64-set and a 4-way/16-set
//                       instance, with a recency-list reference model.
// Rev 1.0
// =============================================================================

module tb_cache_meta_array;

  localparam int S2 = 64;
  localparam int S4 = 16;

  typedef struct packed {
    logic [16:0] exp;
    logic [16:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v2, dty2, rdy2, rv2, rh2, rvv2, rvd2, busy2;
  logic [1:0] op2, rw2, rvw2;
  logic [5:0] idx2, tag2, rvt2;
  logic       v4, dty4, rdy4, rv4, rh4, rvv4, rvd4, busy4;
  logic [1:0] op4;
  logic [3:0] idx4, rw4, rvw4;
  logic [5:0] tag4, rvt4;

  cache_meta_array #(.SETS(S2), .WAYS(2), .TAG_W(6)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(v2), .o_req_ready(rdy2), .i_req_op(op2), .i_req_idx(idx2),
    .i_req_tag(tag2), .i_req_dirty(dty2),
    .o_resp_valid(rv2), .o_resp_hit(rh2), .o_resp_way(rw2), .o_resp_victim_way(rvw2),
    .o_resp_victim_valid(rvv2), .o_resp_victim_dirty(rvd2), .o_resp_victim_tag(rvt2),
    .o_busy(busy2)
  );

  cache_meta_array #(.SETS(S4), .WAYS(4), .TAG_W(6)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(v4), .o_req_ready(rdy4), .i_req_op(op4), .i_req_idx(idx4),
    .i_req_tag(tag4), .i_req_dirty(dty4),
    .o_resp_valid(rv4), .o_resp_hit(rh4), .o_resp_way(rw4), .o_resp_victim_way(rvw4),
    .o_resp_victim_valid(rvv4), .o_resp_victim_dirty(rvd4), .o_resp_victim_tag(rvt4),
    .o_busy(busy4)
  );

  logic [16:0] pack2, pack4;
  assign pack2 = {rh2, 2'b00, rw2, 2'b00, rvw2, rvv2, rvd2, rvt2};
  assign pack4 = {rh4, rw4, rvw4, rvv4, rvd4, rvt4};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-set recency list, index 0 most recently used.
  logic       m_valid [2][64][4];
  logic       m_dirty [2][64][4];
  logic [5:0] m_tag   [2][64][4];
  int         m_order [2][64][4];
  exp_t       q2[$];
  exp_t       q4[$];

  task automatic model_clear(input int d, input bit clr_tags);
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[d][s][w] = 1'b0;
        m_dirty[d][s][w] = 1'b0;
        m_order[d][s][w] = w;
        if (clr_tags) m_tag[d][s][w] = 6'h00;
      end
    end
  endtask

  task automatic touch(input int d, input int idx, input int w);
    int p = 0;
    for (int k = 0; k < 4; k++) if (m_order[d][idx][k] == w) p = k;
    for (int k = p; k > 0; k--) m_order[d][idx][k] = m_order[d][idx][k-1];
    m_order[d][idx][0] = w;
  endtask

  task automatic model_req(input int d, input logic [1:0] op, input int idx,
                           input logic [5:0] tag, input logic dty);
    exp_t       e;
    int         n = (d == 0) ? 2 : 4;
    int         hw = -1;
    int         vw = -1;
    logic       hit;
    logic [3:0] way, vway;
    logic       vvalid, vdirty;
    logic [5:0] vtag;
    if (op == 2'b11) begin
      model_clear(d, 1'b0);
      e.exp  = '0;
      e.mask = '1;
    end else begin
      for (int w = n - 1; w >= 0; w--) begin
        if (m_valid[d][idx][w] && m_tag[d][idx][w] == tag) hw = w;
        if (!m_valid[d][idx][w]) vw = w;
      end
      if (vw < 0) vw = m_order[d][idx][n-1];
      hit    = (hw >= 0);
      way    = 4'h0;
      vway   = 4'(1 << vw);
      vvalid = m_valid[d][idx][vw];
      vdirty = m_dirty[d][idx][vw];
      vtag   = m_tag[d][idx][vw];
      if (op == 2'b10) begin
        if (hit) begin
          way    = 4'(1 << hw);
          vway   = 4'(1 << hw);
          vvalid = 1'b1;
          vdirty = m_dirty[d][idx][hw];
          vtag   = m_tag[d][idx][hw];
          m_valid[d][idx][hw] = 1'b0;
          m_dirty[d][idx][hw] = 1'b0;
        end
      end else if (hit) begin
        way = 4'(1 << hw);
        touch(d, idx, hw);
        if (dty) m_dirty[d][idx][hw] = 1'b1;
      end else if (op == 2'b01) begin
        way = 4'(1 << vw);
        m_tag[d][idx][vw]   = tag;
        m_valid[d][idx][vw] = 1'b1;
        m_dirty[d][idx][vw] = dty;
        touch(d, idx, vw);
      end
      e.exp  = {hit, way, vway, vvalid, vdirty, vtag};
      e.mask = vvalid ? 17'h1FFFF : 17'h1FFC0;
    end
    if (d == 0) q2.push_back(e);
    else q4.push_back(e);
  endtask

  task automatic do_req(input int d, input logic [1:0] op, input int idx,
                        input logic [5:0] tag, input logic dty);
    int n = 0;
    if (d == 0) begin
      v2 = 1'b1; op2 = op; idx2 = idx[5:0]; tag2 = tag; dty2 = dty;
    end else begin
      v4 = 1'b1; op4 = op; idx4 = idx[3:0]; tag4 = tag; dty4 = dty;
    end
    while (!((d == 0) ? rdy2 : rdy4) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("ready_timeout", 32'd0, 32'd1);
      v2 = 1'b0; v4 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    model_req(d, op, idx, tag, dty);
    v2 = 1'b0; v4 = 1'b0;
  endtask

  exp_t e2, e4;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv2) begin
        if (q2.size() == 0) chk("resp2_unexpected", 32'd1, 32'd0);
        else begin
          e2 = q2.pop_front();
          chk("resp2", 32'(pack2 & e2.mask), 32'(e2.exp & e2.mask));
        end
      end
      if (rv4) begin
        if (q4.size() == 0) chk("resp4_unexpected", 32'd1, 32'd0);
        else begin
          e4 = q4.pop_front();
          chk("resp4", 32'(pack4 & e4.mask), 32'(e4.exp & e4.mask));
        end
      end
    end
  end

  logic       perm4_ok, perm2_ok;
  logic [3:0] seen4;
  always @(negedge clk) begin
    if (rst_n) begin
      perm4_ok = 1'b1;
      for (int s = 0; s < S4; s++) begin
        seen4 = 4'h0;
        for (int w = 0; w < 4; w++) seen4[u_dut4.r_age[s][w]] = 1'b1;
        if (seen4 != 4'hF) perm4_ok = 1'b0;
      end
      chk("age_perm4", 32'(perm4_ok), 32'd1);
      perm2_ok = 1'b1;
      for (int s = 0; s < S2; s++) begin
        if (u_dut2.r_age[s][0] == u_dut2.r_age[s][1]) perm2_ok = 1'b0;
      end
      chk("age_perm2", 32'(perm2_ok), 32'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int cnt;
  logic rdy_bad;

  initial begin
    v2 = 0; op2 = 0; idx2 = 0; tag2 = 0; dty2 = 0;
    v4 = 0; op4 = 0; idx4 = 0; tag4 = 0; dty4 = 0;
    model_clear(0, 1'b1);
    model_clear(1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy2), 32'd1);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_resp_valid", 32'(rv2), 32'd0);
    chk("rst_resp_fields", 32'(pack2), 32'd0);
    chk("rst_ready4", 32'(rdy4), 32'd1);
    chk("rst_age4", 32'(u_dut4.r_age[9][3]), 32'd3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss, fill, then hit in set 5.
    do_req(0, 2'b00, 5, 6'h2A, 1'b0);
    chk("s1_miss_vic", 32'({rh2, rvw2, rvv2}), 32'b0010);
    do_req(0, 2'b01, 5, 6'h2A, 1'b0);
    chk("s1_fill_way", 32'(rw2), 32'b01);
    do_req(0, 2'b00, 5, 6'h2A, 1'b0);
    chk("s1_hit", 32'({rh2, rw2}), 32'b101);

    // LRU eviction in set 3.
    do_req(0, 2'b01, 3, 6'h01, 1'b0);
    do_req(0, 2'b01, 3, 6'h02, 1'b0);
    do_req(0, 2'b00, 3, 6'h01, 1'b0);
    do_req(0, 2'b01, 3, 6'h03, 1'b0);
    chk("s2_victim", 32'({rvw2, rvv2, rvt2}), 32'({2'b10, 1'b1, 6'h02}));
    do_req(0, 2'b00, 3, 6'h02, 1'b0);
    chk("s2_evicted_miss", 32'(rh2), 32'd0);

    // Write hit marks dirty; later eviction reports it.
    do_req(0, 2'b01, 7, 6'h11, 1'b0);
    do_req(0, 2'b00, 7, 6'h11, 1'b1);
    do_req(0, 2'b01, 7, 6'h21, 1'b0);
    do_req(0, 2'b01, 7, 6'h22, 1'b0);
    chk("s3_dirty_victim", 32'({rvt2, rvd2}), 32'({6'h11, 1'b1}));

    // Invalidate then refill into the freed way.
    do_req(0, 2'b10, 3, 6'h01, 1'b0);
    chk("s4_inv_hit", 32'({rh2, rvt2}), 32'({1'b1, 6'h01}));
    do_req(0, 2'b00, 3, 6'h01, 1'b0);
    chk("s4_inv_miss", 32'(rh2), 32'd0);
    do_req(0, 2'b01, 3, 6'h05, 1'b0);
    chk("s4_refill_way", 32'(rw2), 32'b01);

    // 4-way LRU order w2,w0,w3,w1 leaves w2 oldest.
    for (int i = 0; i < 4; i++) do_req(1, 2'b01, 0, 6'(8'h30 + i), 1'b0);
    do_req(1, 2'b00, 0, 6'h32, 1'b0);
    do_req(1, 2'b00, 0, 6'h30, 1'b0);
    do_req(1, 2'b00, 0, 6'h33, 1'b0);
    do_req(1, 2'b00, 0, 6'h31, 1'b0);
    do_req(1, 2'b01, 0, 6'h34, 1'b0);
    chk("s5_lru_victim", 32'({rvw4, rvt4}), 32'({4'b0100, 6'h32}));

    // Back-to-back random traffic on a few sets.
    for (int i = 0; i < 150; i++)
      do_req(0, 2'($urandom_range(0, 2)), $urandom_range(0, 3),
             6'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 150; i++)
      do_req(1, 2'($urandom_range(0, 2)), $urandom_range(0, 2),
             6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    // Flush of the 64-set instance.
    do_req(0, 2'b01, 0, 6'h0A, 1'b1);
    do_req(0, 2'b01, S2 - 1, 6'h0B, 1'b0);
    do_req(0, 2'b11, 0, 6'h00, 1'b0);
    cnt = 0;
    rdy_bad = 1'b0;
    while (busy2 && cnt < 100) begin
      if (rdy2) rdy_bad = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    chk("flush_busy_len", 32'(cnt), 32'(S2));
    chk("flush_ready_low", 32'(rdy_bad), 32'd0);
    chk("flush_done_pulse", 32'(rv2), 32'd1);
    chk("flush_ready_back", 32'(rdy2), 32'd1);
    do_req(0, 2'b00, 0, 6'h0A, 1'b0);
    chk("flush_miss0", 32'(rh2), 32'd0);
    do_req(0, 2'b00, S2 - 1, 6'h0B, 1'b0);
    chk("flush_miss_last", 32'(rh2), 32'd0);

    // Reset in the middle of a flush.
    do_req(0, 2'b01, 10, 6'h0C, 1'b0);
    do_req(0, 2'b11, 0, 6'h00, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_ready", 32'(rdy2), 32'd1);
    q2.delete();
    q4.delete();
    model_clear(0, 1'b1);
    model_clear(1, 1'b1);
    #3;
    rst_n = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (rv2) cnt++;
    end
    chk("abort_no_resp", 32'(cnt), 32'd0);
    do_req(0, 2'b00, 10, 6'h0C, 1'b0);
    chk("abort_cleared", 32'(rh2), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_meta_array.md
Name: cache_meta_array

Overview:
Parametrised set-associative metadata store for the I/D caches. It holds tag, valid, dirty and per-way LRU age for every set, and performs tag compare, hit detection and victim selection internally. It supports lookup, fill, invalidate and whole-array flush commands. It sits between the cache controller FSM and the data array, and supplies the hit way and the eviction candidate (tag and dirty) each request.

Parameters:
SETS, 64, number of sets; power of two, at least 2.
WAYS, 2, associativity; 2, 4 or 8.
TAG_W, 6, tag width in bits.
IDX_W, $clog2(SETS), set index width (derived; not overridden).
AGE_W, $clog2(WAYS), LRU age counter width (derived).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  command present this cycle.
req_ready  out  1  command accepted when req_valid & req_ready.
req_op  in  2  00 lookup, 01 fill, 10 invalidate, 11 flush-all.
req_idx  in  IDX_W  set index.
req_tag  in  TAG_W  tag to compare or install.
req_dirty  in  1  lookup: mark the hit way dirty (write hit). Fill: dirty value installed.
resp_valid  out  1  one-cycle pulse with the result.
resp_hit  out  1  tag matched a valid way.
resp_way  out  WAYS  one-hot way index: the hit way on hit, the installed way on fill miss, otherwise 0.
resp_victim_way  out  WAYS  one-hot victim candidate.
resp_victim_valid  out  1  victim way held a valid line.
resp_victim_dirty  out  1  victim way was dirty.
resp_victim_tag  out  TAG_W  tag held in the victim way.
busy  out  1  flush in progress.

Behaviour:
- Reset (async, rst_n=0): all valid and dirty bits cleared; the age of way w is set to w; all resp_* are 0; busy=0; req_ready=1; flush counter is 0.
- Storage is flops. The accepted request's set is read combinationally in the accept cycle. Hit, way and victim are computed and registered, so resp_valid asserts exactly 1 cycle after accept. The state update commits on the same edge.
- Back-to-back requests to the same set see the updated state with no bubble.
- The response reports pre-update contents: victim tag, dirty and valid as they were before the command.
- Hit: some way w has valid[w]=1 and tag[w]==req_tag. Multiple matches are illegal; the lowest index wins and it is a bench assertion.
- Victim selection: the lowest-index invalid way; if every way is valid, the way with age==WAYS-1.
- LRU touch of way w: every way with age < age[w] increments; age[w] becomes 0. Ages remain a permutation of 0..WAYS-1 at all times.
- Lookup hit: touch the hit way. If req_dirty=1, set dirty on that way.
- Lookup miss: no state change. Report the victim; resp_way=0.
- Fill hit (tag already present): touch the matching way, OR req_dirty into its dirty bit, set resp_hit=1 and resp_way=the matching way. No eviction.
- Fill miss: write req_tag into the victim way, set valid=1 and dirty=req_dirty, touch it. Set resp_way=resp_victim_way. The controller writes back when resp_victim_valid & resp_victim_dirty.
- Invalidate hit: clear valid and dirty of the hit way; its age is unchanged. Report the pre-clear tag and dirty via the victim fields, with victim_way=the hit way.
- Invalidate miss: no change; resp_hit=0.
- Flush (op 11): req_idx and req_tag are ignored.
  - busy=1 and req_ready=0 for SETS cycles starting the cycle after accept.
  - One set is cleared per cycle, index 0 to SETS-1: valid and dirty cleared, ages restored to way index.
  - On the cycle busy falls, resp_valid pulses with resp_hit=0 and all way/victim fields 0.
  - req_ready rises the cycle after the last set is cleared.
- req_valid while req_ready=0 is not accepted. The requester holds it, and no state change or response occurs.
- Reset asserted mid-flush aborts immediately to the reset state; no resp_valid.
- resp_* fields hold their last value when resp_valid=0.

Test Plan:
- WAYS=2, SETS=64 after reset: lookup idx 5 tag 0x2A → resp_hit=0, victim_way=01, victim_valid=0. Fill the same → resp_way=01. Lookup again → hit, resp_way=01.
- Fill tags 0x01 then 0x02 into set 3, lookup 0x01, then fill 0x03 → victim_way=10, victim_tag=0x02, victim_valid=1. Lookup 0x02 → miss.
- Lookup set 7 tag 0x11 with req_dirty=1 after filling it clean. Then fill two new tags in set 7 → the second fill reports victim_tag=0x11, victim_dirty=1.
- WAYS=4: fill 4 tags in set 0, access order w2,w0,w3,w1. Next fill miss → victim_way=0100. Ages checked as a permutation every cycle.
- Invalidate a present tag → resp_hit=1, victim_tag equals it; the following lookup misses; the next fill installs into that now-invalid way.
- Fill sets 0 and SETS-1, then flush → busy high exactly SETS cycles, req_ready=0, one resp_valid pulse at the end. All lookups then miss. A second run pulses rst_n low mid-flush → busy=0 immediately and no resp_valid.
